coin_acceptor: RTL and testbench
================================

# coin_acceptor

Front end of the vending datapath: accepts coin insertions one per cycle, accumulates customer credit, settles purchases against a presented price, and hands the residual change amount (in cents) to the change dispenser through a valid/ack handshake. It is the producer of the 32-bit change value that the downstream coin-breakdown logic consumes. All state and outputs are registered on `clk`.

## Interface

Parameters:
- `MAX_CREDIT`, default 500: maximum credit in cents; any coin that would push credit above it is rejected.
- `CREDIT_W`, default 16: internal credit and price width in bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `coin_valid`  in  1  one coin is presented this cycle.
- `coin_type`  in  2  coin code: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 invalid.
- `buy`  in  1  purchase request this cycle.
- `price`  in  CREDIT_W  item price in cents, sampled with `buy`.
- `cancel`  in  1  refund request this cycle.
- `change_ack`  in  1  dispenser has taken `change`.
- `credit`  out  CREDIT_W  current accumulated credit.
- `vend`  out  1  one-cycle pulse when a purchase succeeds.
- `insufficient`  out  1  one-cycle pulse when `buy` is refused.
- `coin_reject`  out  1  one-cycle pulse when a presented coin is returned.
- `change_valid`  out  1  `change` holds a payout amount.
- `change`  out  32  payout in cents, zero-extended from CREDIT_W.

## Operation

- States: IDLE (credit = 0), CREDIT (credit > 0), PAYOUT (waiting on dispenser).
- Coin value map: 00→5, 01→10, 10→25.
- In IDLE or CREDIT, events are evaluated in priority order `cancel` > `buy` > coin, against the credit at the start of the cycle.
- Cancel: if credit > 0, load `change` = credit, set credit = 0, go to PAYOUT. If credit = 0, cancel is ignored.
- Buy: accepted if price ≠ 0 and credit ≥ price. Pulse `vend`, set credit = 0, and load residual = credit − price. If the residual is > 0, go to PAYOUT with `change` = residual; otherwise go to IDLE. Refused if price = 0 or credit < price: pulse `insufficient`, credit unchanged.
- Coin accepted only when all of the following hold: code ≠ 11, no cancel or accepted buy in the same cycle, and credit + value ≤ MAX_CREDIT. An accepted coin sets credit += value and moves the state to CREDIT. Any coin not accepted pulses `coin_reject`.
- A buy that is refused in the same cycle does not block an accompanying coin.
- PAYOUT: `change_valid` = 1 and `change` is held stable. `buy` and `cancel` are ignored. Any `coin_valid` pulses `coin_reject`. On `change_ack` sampled high, go to IDLE.
- Credit arithmetic uses CREDIT_W+1 bits internally, so the ≤ MAX_CREDIT check cannot wrap.

## Timing

- Reset values: state IDLE; credit 0, change 0, change_valid 0, vend 0, insufficient 0, coin_reject 0.
- Reset overrides every input in the same cycle. Reset during PAYOUT drops `change_valid` the next cycle and forfeits the amount.
- All responses appear one cycle after the input edge at which they are sampled: credit update, `vend`, `insufficient`, `coin_reject`, and `change_valid` rise.
- Every pulse output is exactly one cycle wide, even if its input is held high.
- `change_valid` falls the cycle after `change_ack` is sampled high, and `change` returns to 0 in that same cycle. `change_ack` is ignored outside PAYOUT.
- Minimum payout occupancy: 1 cycle, when ack is already high on entry.
- Back-to-back coins every cycle are legal and each is counted.

## Test plan

- Reset, then one quarter and two dimes on consecutive cycles → credit 25, 35, 45; no rejects.
- Credit 45, buy with price 35 → next cycle `vend` = 1, credit 0, `change_valid` = 1, `change` = 10; ack after 3 cycles → `change_valid` low, state IDLE.
- Credit 20, buy with price 35 → `insufficient` pulse, credit stays 20. Buy with price 20 → `vend`, no PAYOUT entry.
- Credit 490, quarter → `coin_reject`, credit 490. Nickel → credit 495. `coin_type` 11 → `coin_reject`.
- Credit 30, cancel and dime in the same cycle → `coin_reject`, PAYOUT with `change` = 30. A coin during PAYOUT → `coin_reject`. Buy during PAYOUT → ignored.
- In PAYOUT with `change` = 15, assert rst → next cycle all outputs zero; a subsequent nickel → credit 5.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: coin/purchase/cancel requests in, credit, status pulses and change handshake out.
// master drives the requests and the change acknowledge; slave is the acceptor itself.
interface coin_acceptor_if #(
    parameter int unsigned CREDIT_W = 16
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                buy;
    logic [CREDIT_W-1:0] price;
    logic                cancel;
    logic                change_ack;
    logic [CREDIT_W-1:0] credit;
    logic                vend;
    logic                insufficient;
    logic                coin_reject;
    logic                change_valid;
    logic [31:0]         change;

    modport master (
        output coin_valid, coin_type, buy, price, cancel, change_ack,
        input  credit, vend, insufficient, coin_reject, change_valid, change
    );

    modport slave (
        input  coin_valid, coin_type, buy, price, cancel, change_ack,
        output credit, vend, insufficient, coin_reject, change_valid, change
    );
endinterface

// File: rtl/coin_acceptor.sv
// Vending front end: accumulates coin credit, settles purchases against a price and hands
// leftover change to the dispenser over a valid/ack handshake. Every output is a flop.
module coin_acceptor #(
    parameter int unsigned MAX_CREDIT = 500,
    parameter int unsigned CREDIT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    coin_acceptor_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCredit, StPayout} state_e;

    localparam logic [CREDIT_W:0] MaxCredit = (CREDIT_W + 1)'(MAX_CREDIT);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                change_valid_q, change_valid_d;
    logic                vend_q, vend_d;
    logic                insufficient_q, insufficient_d;
    logic                coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_code_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                cancel_ok;
    logic                buy_ok;
    logic [CREDIT_W-1:0] residual;

    always_comb begin
        coin_val     = '0;
        coin_code_ok = 1'b1;
        unique case (bus.coin_type)
            2'b00:   coin_val = CREDIT_W'(5);
            2'b01:   coin_val = CREDIT_W'(10);
            2'b10:   coin_val = CREDIT_W'(25);
            default: coin_code_ok = 1'b0;
        endcase
    end

    // One extra bit so credit + coin cannot wrap past MAX_CREDIT.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = coin_sum <= MaxCredit;
    assign cancel_ok = bus.cancel && (credit_q != '0);
    assign buy_ok    = bus.buy && (bus.price != '0) && (credit_q >= bus.price);
    // Only meaningful when buy_ok, where credit >= price guarantees no underflow.
    assign residual  = credit_q - bus.price;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = change_valid_q;
        vend_d         = 1'b0;
        insufficient_d = 1'b0;
        coin_reject_d  = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (cancel_ok) begin
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    coin_reject_d  = bus.coin_valid;
                    state_d        = StPayout;
                end else if (buy_ok) begin
                    vend_d        = 1'b1;
                    credit_d      = '0;
                    coin_reject_d = bus.coin_valid;
                    if (residual != '0) begin
                        change_d       = residual;
                        change_valid_d = 1'b1;
                        state_d        = StPayout;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    // A refused buy still lets a coin in this cycle.
                    insufficient_d = bus.buy;
                    if (bus.coin_valid) begin
                        if (coin_code_ok && coin_fits) begin
                            credit_d = credit_q + coin_val;
                            state_d  = StCredit;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            StPayout: begin
                coin_reject_d = bus.coin_valid;
                if (bus.change_ack) begin
                    change_d       = '0;
                    change_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d        = StIdle;
                credit_d       = '0;
                change_d       = '0;
                change_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            vend_q         <= 1'b0;
            insufficient_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            vend_q         <= vend_d;
            insufficient_q <= insufficient_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.change       = 32'(change_q);
    assign bus.change_valid = change_valid_q;
    assign bus.vend         = vend_q;
    assign bus.insufficient = insufficient_q;
    assign bus.coin_reject  = coin_reject_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios then random traffic, each cycle checked
// against a simple integer model of credit, payout and the status pulses.
module tb_coin_acceptor;
    localparam int unsigned CW   = 16;
    localparam int unsigned MAXC = 500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    coin_acceptor_if #(.CREDIT_W(CW)) bus ();

    coin_acceptor #(
        .MAX_CREDIT(MAXC),
        .CREDIT_W  (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int m_credit = 0;
    int m_change = 0;
    bit m_payout = 0;
    bit m_vend   = 0;
    bit m_insuff = 0;
    bit m_rej    = 0;

    task automatic model_step();
        int val;
        m_vend   = 0;
        m_insuff = 0;
        m_rej    = 0;
        if (rst) begin
            m_credit = 0;
            m_change = 0;
            m_payout = 0;
            return;
        end
        if (m_payout) begin
            m_rej = bus.coin_valid;
            if (bus.change_ack) begin
                m_payout = 0;
                m_change = 0;
            end
            return;
        end
        case (bus.coin_type)
            2'd0:    val = 5;
            2'd1:    val = 10;
            2'd2:    val = 25;
            default: val = 0;
        endcase
        if (bus.cancel && m_credit > 0) begin
            m_change = m_credit;
            m_credit = 0;
            m_payout = 1;
            m_rej    = bus.coin_valid;
        end else if (bus.buy && bus.price != 0 && m_credit >= int'(bus.price)) begin
            m_vend   = 1;
            m_change = m_credit - int'(bus.price);
            m_credit = 0;
            m_payout = (m_change > 0);
            m_rej    = bus.coin_valid;
        end else begin
            m_insuff = bus.buy;
            if (bus.coin_valid) begin
                if (bus.coin_type != 2'd3 && m_credit + val <= int'(MAXC)) m_credit += val;
                else m_rej = 1;
            end
        end
    endtask

    task automatic check_out(string tag);
        checks++;
        assert (bus.credit === CW'(m_credit)) else begin
            errors++;
            $error("FAIL %s credit got %0d exp %0d", tag, bus.credit, m_credit);
        end
        checks++;
        assert (bus.vend === m_vend) else begin
            errors++;
            $error("FAIL %s vend got %b exp %b", tag, bus.vend, m_vend);
        end
        checks++;
        assert (bus.insufficient === m_insuff) else begin
            errors++;
            $error("FAIL %s insufficient got %b exp %b", tag, bus.insufficient, m_insuff);
        end
        checks++;
        assert (bus.coin_reject === m_rej) else begin
            errors++;
            $error("FAIL %s coin_reject got %b exp %b", tag, bus.coin_reject, m_rej);
        end
        checks++;
        assert (bus.change_valid === m_payout) else begin
            errors++;
            $error("FAIL %s change_valid got %b exp %b", tag, bus.change_valid, m_payout);
        end
        checks++;
        assert (bus.change === 32'(m_change)) else begin
            errors++;
            $error("FAIL %s change got %0d exp %0d", tag, bus.change, m_change);
        end
    endtask

    task automatic expect_val(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(bit cv, logic [1:0] ct, bit b, int p, bit c, bit a);
        bus.coin_valid = cv;
        bus.coin_type  = ct;
        bus.buy        = b;
        bus.price      = CW'(p);
        bus.cancel     = c;
        bus.change_ack = a;
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        set_in(0, 2'd0, 0, 0, 0, 0);
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;

        // Quarter, dime, dime.
        set_in(1, 2'd2, 0, 0, 0, 0); tick("coin_q");
        expect_val("credit25", int'(bus.credit), 25);
        set_in(1, 2'd1, 0, 0, 0, 0); tick("coin_d1");
        expect_val("credit35", int'(bus.credit), 35);
        set_in(1, 2'd1, 0, 0, 0, 0); tick("coin_d2");
        expect_val("credit45", int'(bus.credit), 45);

        // Buy 35 from 45 -> change 10, ack after three cycles.
        set_in(0, 2'd0, 1, 35, 0, 0); tick("buy35");
        expect_val("vend_buy35", int'(bus.vend), 1);
        expect_val("change10", int'(bus.change), 10);
        set_in(0, 2'd0, 0, 0, 0, 0); tick("hold1");
        tick("hold2");
        set_in(0, 2'd0, 0, 0, 0, 1); tick("ack");
        expect_val("valid_after_ack", int'(bus.change_valid), 0);
        set_in(0, 2'd0, 0, 0, 0, 0); tick("idle");

        // Credit 20: short buy refused, exact buy vends without payout.
        set_in(1, 2'd1, 0, 0, 0, 0); tick("d_a");
        tick("d_b");
        set_in(0, 2'd0, 1, 35, 0, 0); tick("buy_short");
        expect_val("insuff", int'(bus.insufficient), 1);
        expect_val("credit20", int'(bus.credit), 20);
        set_in(0, 2'd0, 1, 20, 0, 0); tick("buy_exact");
        expect_val("no_payout", int'(bus.change_valid), 0);

        // Fill to 490, then overflow, nickel and invalid code.
        for (int i = 0; i < 19; i++) begin
            set_in(1, 2'd2, 0, 0, 0, 0); tick("fill_q");
        end
        set_in(1, 2'd1, 0, 0, 0, 0); tick("fill_d");
        set_in(1, 2'd0, 0, 0, 0, 0); tick("fill_n");
        expect_val("credit490", int'(bus.credit), 490);
        set_in(1, 2'd2, 0, 0, 0, 0); tick("over_q");
        expect_val("reject_over", int'(bus.coin_reject), 1);
        set_in(1, 2'd0, 0, 0, 0, 0); tick("n495");
        expect_val("credit495", int'(bus.credit), 495);
        set_in(1, 2'd3, 0, 0, 0, 0); tick("bad_code");
        set_in(0, 2'd0, 0, 0, 1, 0); tick("cancel495");
        set_in(0, 2'd0, 0, 0, 0, 1); tick("ack495");

        // Credit 30: cancel beats a dime; coin and buy during payout.
        set_in(1, 2'd2, 0, 0, 0, 0); tick("c30_q");
        set_in(1, 2'd0, 0, 0, 0, 0); tick("c30_n");
        set_in(1, 2'd1, 0, 0, 1, 0); tick("cancel_dime");
        expect_val("change30", int'(bus.change), 30);
        set_in(1, 2'd0, 0, 0, 0, 0); tick("coin_in_payout");
        set_in(0, 2'd0, 1, 5, 0, 0); tick("buy_in_payout");
        set_in(0, 2'd0, 0, 0, 0, 1); tick("ack30");

        // Reset during payout forfeits change.
        set_in(1, 2'd1, 0, 0, 0, 0); tick("c15_d");
        set_in(1, 2'd0, 0, 0, 0, 0); tick("c15_n");
        set_in(0, 2'd0, 0, 0, 1, 0); tick("cancel15");
        expect_val("change15", int'(bus.change), 15);
        set_in(0, 2'd0, 0, 0, 0, 0);
        rst = 1'b1; tick("rst_payout");
        expect_val("rst_valid", int'(bus.change_valid), 0);
        rst = 1'b0;
        set_in(1, 2'd0, 0, 0, 0, 0); tick("after_rst");
        expect_val("credit5", int'(bus.credit), 5);

        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 5) == 0,
                   (($urandom % 3) == 0) ? int'($urandom % 30) : int'($urandom % 520),
                   ($urandom % 12) == 0, ($urandom % 3) == 0);
            rst = (($urandom % 200) == 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
